// File: rtl/cga_pkg.sv
// Shared types for the CGA video-RAM arbiter: FSM states, posted-write entry,
// default framebuffer window base.
package cga_pkg;

    // bus_a[19:15] value selecting the B8000-BFFFF framebuffer window
    localparam logic [4:0] CGA_FB_BASE = 5'h17;

    typedef enum logic [2:0] {
        IDLE,
        WR_FULL,
        RD_WAIT,
        RD_ISSUE,
        RD_DATA,
        RD_HOLD
    } cga_state_t;

    typedef struct packed {
        logic [18:0] addr;
        logic [7:0]  data;
    } cga_wr_entry_t;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// ISA memory-cycle signals seen by the video-RAM arbiter.
// master = ISA/CPU side, slave = arbiter.
interface cga_vram_arbiter_if;
    logic [19:0] bus_a;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out;
    logic        bus_dir;
    logic        bus_rdy;

    modport master (
        output bus_a, bus_memr_l, bus_memw_l, bus_d,
        input  bus_out, bus_dir, bus_rdy
    );

    modport slave (
        input  bus_a, bus_memr_l, bus_memw_l, bus_d,
        output bus_out, bus_dir, bus_rdy
    );
endinterface

// File: rtl/cga_wr_fifo.sv
// Posted-write FIFO for CPU writes into video RAM. DEPTH must be a power of
// two so the pointers wrap naturally; count is one bit wider than the pointers.
module cga_wr_fifo
    import cga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  cga_wr_entry_t          push_entry,
    input  logic                   pop,
    output cga_wr_entry_t          head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    cga_wr_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
endmodule

// File: rtl/cga_vram_arbiter.sv
// Arbitrates the single CGA/Tandy video SRAM between video fetch slots and
// ISA CPU cycles. CPU writes are posted into a FIFO and drained in non-video
// slots; CPU reads wait for the FIFO to drain and for a free slot.
// Build option CGA_SNOW_EN: FIFO drains may steal video slots and the video
// path then sees the written byte (original CGA snow).
//
// state    | meaning
// IDLE     | waiting for an in-window strobe edge
// WR_FULL  | write latched, FIFO full, holding ISA in wait states
// RD_WAIT  | read latched, waiting for empty FIFO and a free slot
// RD_ISSUE | driving the read address in the next free slot
// RD_DATA  | SRAM data returning, captured into bus_out
// RD_HOLD  | bus_out held until the read strobe goes away
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter logic [4:0] FB_BASE     = CGA_FB_BASE,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    cga_vram_arbiter_if.slave        isa,
    input  logic                     vid_read,
    input  logic [18:0]              vid_addr,
    output logic [7:0]               vid_data,
    output logic [18:0]              ram_a,
    input  logic [7:0]               ram_d_in,
    output logic [7:0]               ram_d_out,
    output logic                     ram_we_l
);
    cga_state_t    state, state_n;
    logic [SYNC_STAGES-1:0] memr_sync, memw_sync;
    logic          memr_q, memw_q;
    logic          memr_s, memw_s;
    logic          rd_fall, wr_fall, hit;
    logic [18:0]   cpu_addr, cpu_addr_q;
    logic [7:0]    wr_data_q, bus_out_q;
    logic [18:0]   ram_a_q;
    logic [7:0]    ram_d_q;
    logic          latch_req, rd_issue, capture;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    cga_wr_entry_t push_entry, fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign hit      = (isa.bus_a[19:15] == FB_BASE);
    assign cpu_addr = {4'h0, isa.bus_a[14:0]};
    assign memr_s   = memr_sync[SYNC_STAGES-1];
    assign memw_s   = memw_sync[SYNC_STAGES-1];
    assign rd_fall  = memr_q & ~memr_s;
    assign wr_fall  = memw_q & ~memw_s;

    // strobe synchronisers plus previous-value flops for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            memr_sync <= '1;
            memw_sync <= '1;
            memr_q    <= 1'b1;
            memw_q    <= 1'b1;
        end else begin
            memr_sync[0] <= isa.bus_memr_l;
            memw_sync[0] <= isa.bus_memw_l;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                memr_sync[i] <= memr_sync[i-1];
                memw_sync[i] <= memw_sync[i-1];
            end
            memr_q <= memr_s;
            memw_q <= memw_s;
        end
    end

    // FSM state, latched CPU request and read-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cpu_addr_q <= '0;
            wr_data_q  <= '0;
            bus_out_q  <= '0;
        end else begin
            state <= state_n;
            if (latch_req) begin
                cpu_addr_q <= cpu_addr;
                wr_data_q  <= isa.bus_d;
            end
            if (capture) begin
                bus_out_q <= ram_d_in;
            end
        end
    end

    // next-state and per-cycle FSM actions
    always_comb begin
        state_n    = state;
        latch_req  = 1'b0;
        fifo_push  = 1'b0;
        rd_issue   = 1'b0;
        capture    = 1'b0;
        push_entry = {cpu_addr, isa.bus_d};
        case (state)
            IDLE: begin
                if (wr_fall && hit) begin
                    if (!fifo_full) begin
                        fifo_push = 1'b1;
                    end else begin
                        latch_req = 1'b1;
                        state_n   = WR_FULL;
                    end
                end else if (rd_fall && hit) begin
                    latch_req = 1'b1;
                    state_n   = RD_WAIT;
                end
            end
            WR_FULL: begin
                push_entry = {cpu_addr_q, wr_data_q};
                if (!fifo_full || fifo_pop) begin
                    fifo_push = 1'b1;
                    state_n   = IDLE;
                end
            end
            RD_WAIT: begin
                // draining first keeps read-after-write ordering
                if (fifo_count == '0 && !vid_read) begin
                    state_n = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!vid_read) begin
                    rd_issue = 1'b1;
                    state_n  = RD_DATA;
                end
            end
            RD_DATA: begin
                capture = 1'b1;
                state_n = RD_HOLD;
            end
            RD_HOLD: begin
                if (memr_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef CGA_SNOW_EN
    assign fifo_pop = ~reset & ~fifo_empty;
`else
    assign fifo_pop = ~reset & ~fifo_empty & ~vid_read;
`endif

    cga_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_wr_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push & ~reset),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // SRAM port mux; fifo_pop already excludes video slots unless snow is built in
    always_comb begin
        ram_a     = ram_a_q;
        ram_d_out = ram_d_q;
        ram_we_l  = 1'b1;
        if (reset) begin
            ram_a     = '0;
            ram_d_out = '0;
        end else if (fifo_pop) begin
            ram_a     = fifo_head.addr;
            ram_d_out = fifo_head.data;
            ram_we_l  = 1'b0;
        end else if (vid_read) begin
            ram_a = vid_addr;
        end else if (rd_issue) begin
            ram_a = cpu_addr_q;
        end
    end

    // last driven SRAM address/data, held through idle slots
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_a_q <= '0;
            ram_d_q <= '0;
        end else begin
            ram_a_q <= ram_a;
            ram_d_q <= ram_d_out;
        end
    end

`ifdef CGA_SNOW_EN
    logic       snow_q;
    logic [7:0] snow_data_q;

    // remember a video slot stolen by a write so the pixel path sees the write data
    always_ff @(posedge clk) begin
        if (reset) begin
            snow_q      <= 1'b0;
            snow_data_q <= '0;
        end else begin
            snow_q      <= fifo_pop & vid_read;
            snow_data_q <= ram_d_out;
        end
    end

    assign vid_data = snow_q ? snow_data_q : ram_d_in;
`else
    assign vid_data = ram_d_in;
`endif

    assign isa.bus_out = bus_out_q;
    assign isa.bus_dir = ~reset & hit & ~isa.bus_memr_l;
    assign isa.bus_rdy = reset | ~(state inside {WR_FULL, RD_WAIT, RD_ISSUE, RD_DATA});
endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter with a 1-cycle-latency SRAM model.
module tb_cga_vram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vid_read = 1'b0;
    logic [18:0] vid_addr = 19'h40000;
    logic [7:0]  vid_data;
    logic [18:0] ram_a;
    logic [7:0]  ram_d_in = 8'h00;
    logic [7:0]  ram_d_out;
    logic        ram_we_l;

    always #5 clk = ~clk;

    cga_vram_arbiter_if isa();

    cga_vram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .isa       (isa),
        .vid_read  (vid_read),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .ram_a     (ram_a),
        .ram_d_in  (ram_d_in),
        .ram_d_out (ram_d_out),
        .ram_we_l  (ram_we_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SRAM model with a preload port
    logic [7:0]  sram [0:524287];
    logic        pre_we = 1'b0;
    logic [18:0] pre_a = '0;
    logic [7:0]  pre_d = '0;

    always @(posedge clk) begin
        if (pre_we) sram[pre_a] <= pre_d;
        else if (!ram_we_l) sram[ram_a] <= ram_d_out;
        ram_d_in <= sram[ram_a];
    end

    // video slot pattern: 0 = never, 1 = always, 2 = alternate
    int          vid_mode = 0;
    logic [15:0] vid_cnt = '0;
    always @(posedge clk) begin
        #1;
        vid_cnt = vid_cnt + 16'd1;
        case (vid_mode)
            1:       vid_read = 1'b1;
            2:       vid_read = ~vid_read;
            default: vid_read = 1'b0;
        endcase
        vid_addr = 19'h40000 | {3'b000, vid_cnt};
    end

    // SRAM write log and video-slot guard
    logic [26:0] wlog [$];
    int          vid_err = 0;
    logic        hit_1fff = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (!ram_we_l) wlog.push_back({ram_a, ram_d_out});
            if (vid_read && (ram_a !== vid_addr || ram_we_l !== 1'b1)) vid_err++;
            if (!vid_read && ram_we_l && ram_a == 19'h01FFF) hit_1fff = 1'b1;
        end
    end

    task automatic preload(input logic [18:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic isa_write(input logic [19:0] a, input logic [7:0] d, output logic saw_wait);
        int  k;
        logic done;
        saw_wait = 1'b0;
        done = 1'b0;
        k = 0;
        isa.bus_a = a; isa.bus_d = d; isa.bus_memw_l = 1'b0;
        repeat (3) @(posedge clk);
        while (!done && k < 200) begin
            @(negedge clk);
            if (isa.bus_rdy) done = 1'b1;
            else saw_wait = 1'b1;
            k++;
        end
        if (!done) chk("wr_rdy_timeout", 32'd0, 32'd1);
        isa.bus_memw_l = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic isa_read(input logic [19:0] a, output logic [7:0] d, output int cyc, output logic dir);
        logic done;
        done = 1'b0;
        cyc = 0;
        d = 8'h00;
        isa.bus_a = a; isa.bus_memr_l = 1'b0;
        #1 dir = isa.bus_dir;
        repeat (3) @(posedge clk);
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (isa.bus_rdy) begin
                done = 1'b1;
                d = isa.bus_out;
            end else begin
                cyc++;
            end
        end
        if (!done) chk("rd_rdy_timeout", 32'd0, 32'd1);
        isa.bus_memr_l = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic        dir;
        logic [7:0]  d;
        int          cyc;
        int          base;
        logic [18:0] ra;
        logic        rdy_low;
        logic [26:0] exp_e;

        isa.bus_a = '0; isa.bus_d = '0;
        isa.bus_memr_l = 1'b1; isa.bus_memw_l = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_out", {24'd0, isa.bus_out}, 32'h00);
        chk("rst_bus_dir", {31'd0, isa.bus_dir}, 32'd0);
        chk("rst_bus_rdy", {31'd0, isa.bus_rdy}, 32'd1);
        chk("rst_ram_we_l", {31'd0, ram_we_l}, 32'd1);
        chk("rst_ram_a", {13'd0, ram_a}, 32'h0);
        chk("rst_ram_d_out", {24'd0, ram_d_out}, 32'h00);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single posted write drains immediately
        base = wlog.size();
        isa_write(20'hB8005, 8'h5A, w);
        chk("t1_no_wait", {31'd0, w}, 32'd0);
        chk("t1_wr_count", wlog.size() - base, 32'd1);
        chk("t1_wr_entry", {5'd0, wlog[base]}, {5'd0, 19'h00005, 8'h5A});

        // uncontended read: three wait cycles
        isa_read(20'hB8005, d, cyc, dir);
        chk("t1b_data", {24'd0, d}, 32'h5A);
        chk("t1b_latency", cyc, 32'd3);
        chk("t1b_dir", {31'd0, dir}, 32'd1);

        // five writes while video owns every slot
        vid_mode = 1;
        repeat (2) @(posedge clk); #1;
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            isa_write(20'hB8100 + 20'(i), 8'h10 + 8'(i), w);
            chk("t2_posted_no_wait", {31'd0, w}, 32'd0);
        end
        fork
            isa_write(20'hB8104, 8'h14, rdy_low);
            begin
                repeat (10) @(posedge clk);
                chk("t2_held_by_video", wlog.size() - base, 32'd0);
                vid_mode = 0;
            end
        join
        chk("t2_fifth_waited", {31'd0, rdy_low}, 32'd1);
        repeat (10) @(posedge clk);
        chk("t2_wr_count", wlog.size() - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            exp_e = {19'(19'h00100 + i), 8'(8'h10 + i)};
            chk("t2_wr_order", {5'd0, wlog[base + i]}, {5'd0, exp_e});
        end
        @(negedge clk);
        chk("t2_rdy_back", {31'd0, isa.bus_rdy}, 32'd1);
        @(posedge clk); #1;

        // read-after-write waits for the posted write
        preload(19'h00010, 8'hEE);
        vid_mode = 1;
        repeat (2) @(posedge clk); #1;
        isa_write(20'hB8010, 8'hC3, w);
        chk("t3_wr_no_wait", {31'd0, w}, 32'd0);
        fork
            isa_read(20'hB8010, d, cyc, dir);
            begin
                repeat (12) @(posedge clk);
                vid_mode = 0;
            end
        join
        chk("t3_raw_data", {24'd0, d}, 32'hC3);
        chk("t3_waited", {31'd0, (cyc > 3)}, 32'd1);

        // out-of-window read is ignored
        @(negedge clk);
        ra = ram_a;
        base = wlog.size();
        rdy_low = 1'b0;
        isa.bus_a = 20'hA0000; isa.bus_memr_l = 1'b0;
        #1;
        chk("t4_dir", {31'd0, isa.bus_dir}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!isa.bus_rdy || ram_a !== ra) rdy_low = 1'b1;
        end
        chk("t4_no_wait_no_access", {31'd0, rdy_low}, 32'd0);
        chk("t4_no_writes", wlog.size() - base, 32'd0);
        chk("t4_bus_out_kept", {24'd0, isa.bus_out}, 32'hC3);
        isa.bus_memr_l = 1'b1;
        repeat (4) @(posedge clk); #1;

        // read under alternating video slots
        preload(19'h01FFF, 8'h7E);
        vid_mode = 2;
        isa_read(20'hB9FFF, d, cyc, dir);
        vid_mode = 0;
        chk("t5_data", {24'd0, d}, 32'h7E);
        chk("t5_dir", {31'd0, dir}, 32'd1);
        chk("t5_addr_issued", {31'd0, hit_1fff}, 32'd1);
        chk("t5_delayed", {31'd0, (cyc > 3)}, 32'd1);
        chk("t5_video_intact", vid_err, 32'd0);

        // reset while stalled in WR_FULL with a full FIFO
        vid_mode = 1;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            isa_write(20'hB8200 + 20'(i), 8'hA0 + 8'(i), w);
        end
        base = wlog.size();
        isa.bus_a = 20'hB8204; isa.bus_d = 8'hA4; isa.bus_memw_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_wr_full_wait", {31'd0, isa.bus_rdy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        isa.bus_memw_l = 1'b1;
        #1;
        chk("t6_rdy_in_reset", {31'd0, isa.bus_rdy}, 32'd1);
        chk("t6_we_in_reset", {31'd0, ram_we_l}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        vid_mode = 0;
        @(negedge clk);
        chk("t6_rdy_after", {31'd0, isa.bus_rdy}, 32'd1);
        chk("t6_bus_out_cleared", {24'd0, isa.bus_out}, 32'h00);
        repeat (12) @(posedge clk);
        chk("t6_fifo_discarded", wlog.size() - base, 32'd0);
        chk("final_video_intact", vid_err, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
